// File: rtl/seqsig_pkg.sv
// Shared types and helpers for the serial pattern detector.
// No logic of its own; widths derive from the pattern and counter parameters.
package seqsig_pkg;

    typedef enum logic [1:0] {
        HUNT,
        VERIFY,
        LOCK
    } seqsig_state_t;

    // Bits needed to hold values 0..n-1, never less than one.
    function automatic int phase_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/seqsig_shift_match.sv
// PAT_LEN-bit serial shift register with equality compare against PATTERN.
// hit_o is combinational on the sample being taken; no backpressure, en_i gates shifting.
module seqsig_shift_match #(
    parameter int                 PAT_LEN = 6,
    parameter logic [PAT_LEN-1:0] PATTERN = 6'b110100
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic din_i,
    output logic hit_o
);

    logic [PAT_LEN-1:0] sr_q;
    logic [PAT_LEN-1:0] sr_d;

    assign sr_d  = {sr_q[PAT_LEN-2:0], din_i};
    assign hit_o = en_i && (sr_d == PATTERN);

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q <= '0;
        end else if (en_i) begin
            sr_q <= sr_d;
        end
    end

endmodule

// File: rtl/seqsig_detector.sv
// Finds and locks to a periodic PAT_LEN-bit pattern in a serial stream, then flags bit errors and loss of lock.
// Latency: all outputs registered, 1 cycle after the deciding en sample; no backpressure, en=0 freezes everything.
module seqsig_detector
    import seqsig_pkg::*;
#(
    parameter int                 PAT_LEN  = 6,
    parameter logic [PAT_LEN-1:0] PATTERN  = 6'b110100,
    parameter int                 LOCK_CNT = 2,
    parameter int                 LOSS_CNT = 2,
    parameter int                 ERR_W    = 8,
    localparam int                PW       = phase_w(PAT_LEN)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             din,
    input  logic             clr_err,
    output logic             match,
    output logic             locked,
    output logic [PW-1:0]    phase,
    output logic             bit_err,
    output logic [ERR_W-1:0] err_cnt
);

    localparam int GW = phase_w(LOCK_CNT + 1);
    localparam int BW = phase_w(LOSS_CNT + 1);

    seqsig_state_t    state_q, state_d;
    logic [PW-1:0]    phase_q, phase_d, phase_inc;
    logic [GW-1:0]    good_q, good_d, good_inc;
    logic [BW-1:0]    bad_q, bad_d, bad_inc;
    logic             errd_q, errd_d;
    logic             match_q;
    logic             bit_err_q, bit_err_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
    logic [PAT_LEN-1:0] pat_rev;
    logic             hit;
    logic             mis;
    logic             wrap;

    seqsig_shift_match #(
        .PAT_LEN (PAT_LEN),
        .PATTERN (PATTERN)
    ) u_shift_match (
        .clk   (clk),
        .rst   (rst),
        .en_i  (en),
        .din_i (din),
        .hit_o (hit)
    );

    // Bit-reversed copy so phase 0 indexes the pattern MSB directly.
    for (genvar i = 0; i < PAT_LEN; i++) begin : g_rev
        assign pat_rev[i] = PATTERN[PAT_LEN-1-i];
    end

    assign mis       = en && (din != pat_rev[phase_q]);
    assign wrap      = (phase_q == PW'(PAT_LEN - 1));
    assign phase_inc = wrap ? '0 : phase_q + 1'b1;
    assign good_inc  = good_q + 1'b1;
    assign bad_inc   = bad_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        good_d    = good_q;
        bad_d     = bad_q;
        errd_d    = errd_q;
        bit_err_d = 1'b0;
        case (state_q)
            HUNT: begin
                if (hit) begin
                    state_d = (LOCK_CNT == 1) ? LOCK : VERIFY;
                    phase_d = '0;
                    good_d  = GW'(1);
                    bad_d   = '0;
                    errd_d  = 1'b0;
                end
            end
            VERIFY: begin
                if (mis) begin
                    state_d = HUNT;
                    phase_d = '0;
                    good_d  = '0;
                end else if (en) begin
                    phase_d = phase_inc;
                    if (wrap) begin
                        good_d = good_inc;
                        if (good_inc == GW'(LOCK_CNT)) begin
                            state_d = LOCK;
                        end
                    end
                end
            end
            LOCK: begin
                if (en) begin
                    bit_err_d = mis;
                    phase_d   = phase_inc;
                    errd_d    = errd_q | mis;
                    // The wrapping sample's own error belongs to the period it closes.
                    if (wrap) begin
                        errd_d = 1'b0;
                        if (errd_q || mis) begin
                            bad_d = bad_inc;
                            if (bad_inc == BW'(LOSS_CNT)) begin
                                state_d = HUNT;
                                phase_d = '0;
                                good_d  = '0;
                                bad_d   = '0;
                            end
                        end else begin
                            bad_d = '0;
                        end
                    end
                end
            end
            default: state_d = HUNT;
        endcase

        err_cnt_d = err_cnt_q;
        if (clr_err) begin
            err_cnt_d = ERR_W'(bit_err_d);
        end else if (bit_err_d && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= HUNT;
            phase_q   <= '0;
            good_q    <= '0;
            bad_q     <= '0;
            errd_q    <= 1'b0;
            match_q   <= 1'b0;
            bit_err_q <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            good_q    <= good_d;
            bad_q     <= bad_d;
            errd_q    <= errd_d;
            match_q   <= hit;
            bit_err_q <= bit_err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign match   = match_q;
    assign locked  = (state_q == LOCK);
    assign phase   = phase_q;
    assign bit_err = bit_err_q;
    assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_seqsig_detector.sv
// Randomised and directed checks of seqsig_detector against a sample-by-sample behavioural model.
module tb_seqsig_detector;

    localparam int             L     = 6;
    localparam logic [L-1:0]   PAT   = 6'b110100;
    localparam int             LOCKN = 2;
    localparam int             LOSSN = 2;
    localparam int             EW    = 8;
    localparam int             EMAX  = (1 << EW) - 1;
    localparam int             M_HUNT = 0, M_VER = 1, M_LOCK = 2;

    logic          clk = 1'b0;
    logic          rst, en, din, clr_err;
    logic          match, locked, bit_err;
    logic [2:0]    phase;
    logic [EW-1:0] err_cnt;

    seqsig_detector #(
        .PAT_LEN  (L),
        .PATTERN  (PAT),
        .LOCK_CNT (LOCKN),
        .LOSS_CNT (LOSSN),
        .ERR_W    (EW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .din     (din),
        .clr_err (clr_err),
        .match   (match),
        .locked  (locked),
        .phase   (phase),
        .bit_err (bit_err),
        .err_cnt (err_cnt)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    endtask

    // Behavioural model: sample history plus period bookkeeping.
    bit pat_b[L];
    bit hist[$];
    int m_mode, m_phase, m_good, m_bad, m_err;
    bit m_errd, e_match, e_biterr;

    task automatic model_step(input bit r, input bit e, input bit d, input bit c);
        bit hit, mis;
        e_match  = 1'b0;
        e_biterr = 1'b0;
        mis      = 1'b0;
        if (r) begin
            m_mode = M_HUNT; m_phase = 0; m_good = 0; m_bad = 0; m_err = 0; m_errd = 0;
            hist.delete();
            repeat (L) hist.push_back(1'b0);
            return;
        end
        if (e) begin
            hist.push_back(d);
            void'(hist.pop_front());
            hit = 1'b1;
            for (int k = 0; k < L; k++) if (hist[k] != pat_b[k]) hit = 1'b0;
            e_match = hit;
            if (m_mode == M_HUNT) begin
                if (hit) begin
                    m_mode = (LOCKN == 1) ? M_LOCK : M_VER;
                    m_phase = 0; m_good = 1; m_bad = 0; m_errd = 0;
                end
            end else if (m_mode == M_VER) begin
                if (d != pat_b[m_phase]) begin
                    m_mode = M_HUNT; m_phase = 0; m_good = 0;
                end else begin
                    m_phase = (m_phase + 1) % L;
                    if (m_phase == 0) begin
                        m_good++;
                        if (m_good >= LOCKN) m_mode = M_LOCK;
                    end
                end
            end else begin
                if (d != pat_b[m_phase]) begin
                    mis = 1'b1;
                    m_errd = 1'b1;
                end
                m_phase = (m_phase + 1) % L;
                if (m_phase == 0) begin
                    if (m_errd) begin
                        m_bad++;
                        if (m_bad >= LOSSN) begin
                            m_mode = M_HUNT; m_good = 0; m_bad = 0;
                        end
                    end else begin
                        m_bad = 0;
                    end
                    m_errd = 1'b0;
                end
            end
        end
        if (c) m_err = mis ? 1 : 0;
        else if (mis && m_err < EMAX) m_err++;
        e_biterr = mis;
    endtask

    task automatic cyc(input bit e, input bit d, input bit c = 1'b0, input bit r = 1'b0);
        en = e; din = d; clr_err = c; rst = r;
        @(posedge clk);
        model_step(r, e, d, c);
        #1;
        check("match",   match,   e_match);
        check("locked",  locked,  (m_mode == M_LOCK));
        check("phase",   phase,   m_phase);
        check("bit_err", bit_err, e_biterr);
        check("err_cnt", err_cnt, m_err);
    endtask

    int ptr;

    task automatic pat(input int n, input int flip = -1);
        bit b;
        for (int i = 0; i < n; i++) begin
            b = pat_b[ptr];
            if (i == flip) b = ~b;
            cyc(1'b1, b);
            ptr = (ptr + 1) % L;
        end
    endtask

    task automatic do_reset();
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        ptr = 0;
    endtask

    initial begin
        logic [L-1:0] pv;
        bit e, c, f, b;
        pv = PAT;
        for (int k = 0; k < L; k++) pat_b[k] = pv[L-1-k];
        rst = 1'b1; en = 1'b0; din = 1'b0; clr_err = 1'b0;

        // Clean stream: first match after 6 samples, lock after 12.
        do_reset();
        check("rst_locked", locked, 0);
        pat(5);
        check("no_match_5", match, 0);
        pat(1);
        check("first_match", match, 1);
        pat(5);
        check("not_locked_11", locked, 0);
        pat(1);
        check("lock_at_12", locked, 1);
        pat(18);
        check("clean_errcnt", err_cnt, 0);

        // One flipped bit at phase 3.
        pat(3);
        pat(1, 0);
        check("single_err_pulse", bit_err, 1);
        check("single_err_cnt", err_cnt, 1);
        pat(2);
        pat(6);
        check("single_err_lock", locked, 1);

        // Two consecutive errored periods drop lock, then relock.
        pat(6, 2);
        pat(5, 4);
        check("still_locked", locked, 1);
        pat(1);
        check("loss_after_2", locked, 0);
        check("loss_errcnt", err_cnt, 3);
        pat(12);
        check("relock", locked, 1);

        // clr_err together with a bit error, then a plain clear.
        pat(2);
        cyc(1'b1, ~pat_b[ptr], 1'b1);
        ptr = (ptr + 1) % L;
        check("clr_with_err", err_cnt, 1);
        pat(3);
        pat(6);
        cyc(1'b0, 1'b0, 1'b1);
        check("clr_plain", err_cnt, 0);
        check("clr_keeps_lock", locked, 1);

        // Reset while locked.
        pat(2, 0);
        cyc(1'b1, pat_b[ptr], 1'b0, 1'b1);
        ptr = 0;
        check("rst_lock_locked", locked, 0);
        check("rst_lock_phase", phase, 0);
        check("rst_lock_err", err_cnt, 0);

        // en toggling every cycle.
        for (int i = 0; i < 12; i++) begin
            cyc(1'b1, pat_b[ptr]);
            ptr = (ptr + 1) % L;
            cyc(1'b0, 1'($urandom % 2));
        end
        check("toggle_lock", locked, 1);

        // Noise then the real pattern.
        do_reset();
        for (int i = 0; i < 100; i++) cyc(1'b1, 1'($urandom % 2));
        ptr = 0;
        pat(30);
        check("noise_lock", locked, 1);

        // Randomised enables, clears and flips.
        do_reset();
        pat(12);
        for (int i = 0; i < 600; i++) begin
            e = ($urandom % 4) != 0;
            c = ($urandom % 16) == 0;
            f = ($urandom % 10) == 0;
            b = pat_b[ptr] ^ f;
            cyc(e, b, c);
            if (e) ptr = (ptr + 1) % L;
        end

        // Saturation: one error every other period keeps lock.
        do_reset();
        pat(12);
        for (int k = 0; k < EMAX + 4; k++) begin
            pat(6, 1);
            pat(6);
        end
        check("sat_errcnt", err_cnt, EMAX);
        check("sat_lock", locked, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
